wb_gpio_irq: RTL and testbench
==============================

Name: wb_gpio_irq

Overview:
Wishbone B4 classic slave GPIO peripheral with per-pin direction control, input synchronisation and edge-triggered interrupt capture. It responds to the CPU's Wishbone data-bus accesses through the interconnect. It drives an aggregated interrupt line into one bit of the CPU's irq vector. It replaces plain LED output with a full bidirectional pin bank on the shared gpio_b bus.

Parameters:
GPIO_WIDTH, 32, number of pins (1..32); register bits above GPIO_WIDTH read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth (>=2).
DEBOUNCE_LEN, 1000, sample-strobe period in clk_i cycles; used only with the optional feature.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_n_i  in  1  reset, asynchronous assert, active-low.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  write enable.
wb_adr_i  in  32  byte address; only bits [4:2] decoded.
wb_sel_i  in  4  byte selects.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data.
wb_ack_o  out  1  acknowledge.
irq_o  out  1  level interrupt, high while any enabled status bit is set.
gpio_b  inout  GPIO_WIDTH  pins.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_n_i, asynchronous, active-low.
- Register map (adr[4:2]):
  - 0 DATA_OUT RW
  - 1 DIR RW (1 = drive)
  - 2 DATA_IN RO, synchronised pin value
  - 3 RISE_EN RW
  - 4 FALL_EN RW
  - 5 IRQ_STATUS, read / write-1-to-clear
  - 6,7 read 0; writes ignored.
- Reset (async, rst_n_i low): all registers, sync flops, edge-history flop, wb_ack_o, wb_dat_o and irq_o go to 0. gpio_b is all Z.
- Handshake:
  - wb_ack_o <= cyc & stb & ~wb_ack_o. Ack appears one cycle after the request is sampled and is high exactly one cycle.
  - A strobe held high is acked every other cycle.
  - Unmapped addresses are acked normally. err/rty are not generated.
- Writes commit on the cycle ack is asserted, per byte lane via wb_sel_i. sel=0 still acks with no change.
- wb_dat_o is registered with ack and held until the next read. Writes do not update it.
- Pin drive: gpio_b[i] = DIR[i] ? DATA_OUT[i] : Z.
- Input path: gpio_b passes through a SYNC_STAGES-deep flop chain into DATA_IN. An edge-history flop holds DATA_IN of the previous cycle.
  - Rising edge: DATA_IN & ~prev.
  - Falling edge: ~DATA_IN & prev.
  - Driven pins are read back, so output toggles can raise interrupts.
- IRQ_STATUS[i] is set by (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]) and cleared by writing 1.
  - Set and clear in the same cycle: set wins.
  - Bits stay set after their enable is cleared.
- irq_o = registered OR of IRQ_STATUS. It rises one cycle after the status bit sets and falls one cycle after the last bit clears.
- After reset, a pin held high produces a rising edge SYNC_STAGES cycles later. RISE_EN is 0 at that point, so no status is set.
- Latency from pin edge to irq_o: SYNC_STAGES+2 cycles.
- Reset mid-transfer: the transfer is abandoned with no ack. The master must restart it.

Optional Feature:
Macro WB_GPIO_DEBOUNCE_EN.
- Defined:
  - A free-running counter emits a one-cycle strobe every DEBOUNCE_LEN cycles.
  - On each strobe, the synchroniser output is sampled. DATA_IN[i] updates only when two consecutive strobe samples agree.
  - The counter resets to 0.
  - Edge detection uses debounced DATA_IN, so pin-to-irq latency grows by up to 2*DEBOUNCE_LEN cycles.
- Undefined: DATA_IN is the raw synchroniser output, with no counter or sample logic.

Test Plan:
1. Reset then read all 8 addresses -> every read returns 0x00000000; each ack lasts exactly one cycle, one cycle after stb.
2. Write DIR=0x000000FF and DATA_OUT=0xA5A5A5A5 with sel=4'b0001 -> DATA_OUT reads 0x000000A5; gpio_b[7:0]=0xA5; gpio_b[31:8]=Z.
3. DIR=0, RISE_EN=0x1; drive gpio_b[0] 0->1 -> IRQ_STATUS=0x1 and irq_o=1 after SYNC_STAGES+2 cycles. Write IRQ_STATUS=0x1 -> irq_o=0 one cycle later.
4. FALL_EN=0x8; pulse gpio_b[3] 1->0 in the same cycle the bench writes IRQ_STATUS=0x8 -> bit 3 remains set (set wins).
5. Hold stb+cyc high for 6 cycles -> exactly 3 ack pulses. Assert rst_n_i low mid-access -> ack drops asynchronously and all registers read 0 afterwards.
6. With WB_GPIO_DEBOUNCE_EN and DEBOUNCE_LEN=4, toggle gpio_b[1] for 3 cycles -> DATA_IN[1] unchanged. Hold it for 12 cycles -> DATA_IN[1]=1.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone B4 classic GPIO bank with input sync and edge interrupts
//
// Ports:
//   clk_i, rst_n_i     : clock (rising edge) and asynchronous active-low reset
//   wb_cyc_i/wb_stb_i  : Wishbone cycle and strobe
//   wb_we_i, wb_sel_i  : write enable and byte-lane selects
//   wb_adr_i           : byte address, bits [4:2] select the register
//   wb_dat_i/wb_dat_o  : write data / registered read data
//   wb_ack_o           : one-cycle acknowledge
//   irq_o              : registered OR of IRQ_STATUS
//   gpio_b             : bidirectional pins, driven where DIR=1
//
// Register map (adr[4:2]): 0 DATA_OUT, 1 DIR, 2 DATA_IN (RO), 3 RISE_EN,
//   4 FALL_EN, 5 IRQ_STATUS (W1C), 6-7 read zero.
//
// Optional macro WB_GPIO_DEBOUNCE_EN: DATA_IN only follows the synchroniser
// once two consecutive samples, taken every DEBOUNCE_LEN cycles, agree.

module wb_gpio_irq #(
    parameter int GPIO_WIDTH   = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_LEN = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  irq_o,
    inout  wire  [GPIO_WIDTH-1:0] gpio_b
);

    localparam logic [2:0] ADR_DOUT = 3'd0;
    localparam logic [2:0] ADR_DIR  = 3'd1;
    localparam logic [2:0] ADR_DIN  = 3'd2;
    localparam logic [2:0] ADR_RISE = 3'd3;
    localparam logic [2:0] ADR_FALL = 3'd4;
    localparam logic [2:0] ADR_STAT = 3'd5;

    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] cur,
                                                    input logic [31:0] wdata,
                                                    input logic [31:0] bmask);
        logic [31:0] m;
        m = (zext(cur) & ~bmask) | (wdata & bmask);
        return m[GPIO_WIDTH-1:0];
    endfunction

    logic                  unused_adr;
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    logic                  ack_q, ack_d;
    logic [31:0]           dat_o_q, dat_o_d;
    logic [GPIO_WIDTH-1:0] dout_q, dout_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d;
    logic [GPIO_WIDTH-1:0] prev_q, prev_d;
    logic                  irq_q, irq_d;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] sync_d [SYNC_STAGES];

    logic [GPIO_WIDTH-1:0] sync_out;
    logic [GPIO_WIDTH-1:0] data_in;
    logic [GPIO_WIDTH-1:0] rise, fall, set_v, clr_v;
    logic [31:0]           byte_mask, wdata_masked, rdata;
    logic [2:0]            adr;
    logic                  req, wr, rd;

    // Pin drivers
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        assign gpio_b[i] = dir_q[i] ? dout_q[i] : 1'bz;
    end

    // Input synchroniser chain
    always_comb begin
        sync_d[0] = gpio_b;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef WB_GPIO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0] samp_q, samp_d;
    logic [GPIO_WIDTH-1:0] din_q, din_d;
    logic [GPIO_WIDTH-1:0] agree;
    logic                  strobe;

    // Each strobe compares the fresh sample with the previous one; only the
    // bits that match in both samples are allowed to move DATA_IN.
    always_comb begin
        strobe = (cnt_q == CW'(DEBOUNCE_LEN - 1));
        cnt_d  = strobe ? '0 : cnt_q + 1'b1;
        agree  = ~(sync_out ^ samp_q);
        samp_d = strobe ? sync_out : samp_q;
        din_d  = din_q;
        if (strobe) begin
            din_d = (din_q & ~agree) | (sync_out & agree);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            samp_q <= '0;
            din_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            din_q  <= din_d;
        end
    end

    assign data_in = din_q;
`else
    localparam int unused_debounce_len = DEBOUNCE_LEN;

    assign data_in = sync_out;
`endif

    // Bus decode, register updates and edge capture
    always_comb begin
        adr          = wb_adr_i[4:2];
        req          = wb_cyc_i & wb_stb_i & ~ack_q;
        wr           = req & wb_we_i;
        rd           = req & ~wb_we_i;
        ack_d        = req;
        byte_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wdata_masked = wb_dat_i & byte_mask;

        unique case (adr)
            ADR_DOUT: rdata = zext(dout_q);
            ADR_DIR:  rdata = zext(dir_q);
            ADR_DIN:  rdata = zext(data_in);
            ADR_RISE: rdata = zext(rise_en_q);
            ADR_FALL: rdata = zext(fall_en_q);
            ADR_STAT: rdata = zext(status_q);
            default:  rdata = '0;
        endcase

        dat_o_d   = rd ? rdata : dat_o_q;
        dout_d    = (wr && adr == ADR_DOUT) ? merge(dout_q, wb_dat_i, byte_mask) : dout_q;
        dir_d     = (wr && adr == ADR_DIR)  ? merge(dir_q, wb_dat_i, byte_mask) : dir_q;
        rise_en_d = (wr && adr == ADR_RISE) ? merge(rise_en_q, wb_dat_i, byte_mask) : rise_en_q;
        fall_en_d = (wr && adr == ADR_FALL) ? merge(fall_en_q, wb_dat_i, byte_mask) : fall_en_q;

        prev_d = data_in;
        rise   = data_in & ~prev_q;
        fall   = ~data_in & prev_q;
        set_v  = (rise & rise_en_q) | (fall & fall_en_q);
        clr_v  = (wr && adr == ADR_STAT) ? wdata_masked[GPIO_WIDTH-1:0] : '0;
        // OR-ing the set term after the clear lets a new edge win over W1C.
        status_d = (status_q & ~clr_v) | set_v;
        irq_d    = |status_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
            dout_q    <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_o_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb/tb_wb_gpio_irq.sv - directed scoreboard bench for wb_gpio_irq

module tb_wb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    wire  [31:0] dat_r;
    wire         ack, irq;
    wire  [31:0] gpio;
    logic [31:0] tb_oe, tb_val;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    wb_gpio_irq #(
        .GPIO_WIDTH  (32),
        .SYNC_STAGES (2),
        .DEBOUNCE_LEN(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i (we),
        .wb_adr_i(adr),
        .wb_sel_i(sel),
        .wb_dat_i(dat_w),
        .wb_dat_o(dat_r),
        .wb_ack_o(ack),
        .irq_o   (irq),
        .gpio_b  (gpio)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read: expected data goes onto the scoreboard at issue and is popped when ack appears.
    task automatic wb_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        exp_q.push_back(exp);
        check({tag, "_ack_pre"}, {31'b0, ack}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'b0, a, 2'b00}; sel = 4'hF;
        tick();
        check({tag, "_ack"}, {31'b0, ack}, 32'd1);
        e = exp_q.pop_front();
        check({tag, "_data"}, dat_r, e);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check({tag, "_ack_drop"}, {31'b0, ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag, output logic irq_at_commit);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'b0, a, 2'b00}; dat_w = d; sel = s;
        tick();
        check({tag, "_ack"}, {31'b0, ack}, 32'd1);
        irq_at_commit = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check({tag, "_ack_drop"}, {31'b0, ack}, 32'd0);
    endtask

    initial begin
        logic        irq_c;
        logic [31:0] irq_hist;
        int          acks;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0;
        tb_oe = 32'hFFFF_FFFF; tb_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: every address reads zero after reset
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), 32'h0, $sformatf("t1_rd%0d", a));
        end

        // 2: byte-lane write and pin drive
        tb_oe  = 32'hFFFF_FF00;
        tb_val = 32'h5A5A_5A00;
        wb_write(3'd1, 32'h0000_00FF, 4'hF, "t2_dir", irq_c);
        wb_write(3'd0, 32'hA5A5_A5A5, 4'b0001, "t2_dout", irq_c);
        wb_read(3'd0, 32'h0000_00A5, "t2_dout_rd");
        check("t2_pins_lo", {24'b0, gpio[7:0]}, 32'h0000_00A5);
        repeat (12) tick();
        wb_read(3'd2, 32'h5A5A_5AA5, "t2_din_rd");
        wb_read(3'd1, 32'h0000_00FF, "t2_dir_rd");
        wb_read(3'd5, 32'h0, "t2_stat_rd");
        wb_write(3'd1, 32'h0, 4'hF, "t2_dir_clr", irq_c);
        tb_oe  = 32'hFFFF_FFFF;
        tb_val = 32'h0;
        repeat (12) tick();

`ifndef WB_GPIO_DEBOUNCE_EN
        // 3: rising edge on pin 0 -> irq after SYNC_STAGES+2 cycles, W1C clears it
        wb_write(3'd3, 32'h1, 4'hF, "t3_rise_en", irq_c);
        tb_val[0] = 1'b1;
        irq_hist = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            irq_hist[k] = irq;
        end
        check("t3_irq_early", {31'b0, irq_hist[3]}, 32'd0);
        check("t3_irq_lat", {31'b0, irq_hist[4]}, 32'd1);
        wb_read(3'd5, 32'h1, "t3_stat_rd");
        wb_write(3'd5, 32'h1, 4'hF, "t3_w1c", irq_c);
        check("t3_irq_commit", {31'b0, irq_c}, 32'd1);
        check("t3_irq_fall", {31'b0, irq}, 32'd0);
        wb_read(3'd5, 32'h0, "t3_stat_clr");

        // 4: falling edge on pin 3 coincides with W1C of bit 3 -> set wins
        wb_write(3'd4, 32'h8, 4'hF, "t4_fall_en", irq_c);
        tb_val[3] = 1'b1;
        repeat (4) tick();
        wb_read(3'd5, 32'h0, "t4_stat_pre");
        tb_val[3] = 1'b0;
        repeat (2) tick();
        wb_write(3'd5, 32'h8, 4'hF, "t4_w1c", irq_c);
        check("t4_irq", {31'b0, irq}, 32'd1);
        wb_read(3'd5, 32'h8, "t4_set_wins");
        wb_write(3'd5, 32'h8, 4'hF, "t4_w1c2", irq_c);
        wb_read(3'd5, 32'h0, "t4_stat_clr");
`endif

        // 5: held strobe acks every other cycle; reset mid-access
        tb_val = 32'h0;
        repeat (4) tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack) acks++;
        end
        check("t5_ack_count", 32'(acks), 32'd3);
        tick();
        check("t5_ack_hi", {31'b0, ack}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_ack", {31'b0, ack}, 32'd0);
        check("t5_async_irq", {31'b0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), 32'h0, $sformatf("t5_rd%0d", a));
        end

`ifdef WB_GPIO_DEBOUNCE_EN
        // 6: short glitch is rejected, steady level is accepted
        tb_val[1] = 1'b1; tick();
        tb_val[1] = 1'b0; tick();
        tb_val[1] = 1'b1; tick();
        tb_val[1] = 1'b0;
        repeat (12) tick();
        wb_read(3'd2, 32'h0, "t6_glitch");
        tb_val[1] = 1'b1;
        repeat (12) tick();
        wb_read(3'd2, 32'h2, "t6_steady");
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
